// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register with load alignment and byte-enabled register writeback
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [3:0]  mem_wreg,
    input  logic [4:0]  mem_wraddr,
    input  logic [31:0] mem_alures,
    input  logic [2:0]  mem_ldop,
    input  logic [1:0]  mem_addr_lo,
    input  logic        stall,
    input  logic        flush,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic [3:0]  we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        wb_stall
);
    typedef enum logic [1:0] {EMPTY, WRITE, WAIT} state_t;
    state_t      state_q, state_d;
    logic [3:0]  wreg_q, wreg_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] alures_q, alures_d;
    logic [2:0]  ldop_q, ldop_d;
    logic [1:0]  alo_q, alo_d;
    logic        cap, drop;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  ld_we;
    logic [31:0] ld_data;
    always_comb begin
        cap = !stall && !(state_q == WAIT && !dbus_rvalid);
        drop = flush || !mem_valid || mem_wreg == 4'b0000;
        state_d = (state_q == WAIT && !dbus_rvalid) ? WAIT : EMPTY;
        wreg_d = wreg_q;
        waddr_d = waddr_q;
        alures_d = alures_q;
        ldop_d = ldop_q;
        alo_d = alo_q;
        if (cap) state_d = drop ? EMPTY : (mem_ldop != 3'd0) ? WAIT : WRITE;
        if (cap && !drop) begin
            wreg_d = mem_wreg;
            waddr_d = mem_wraddr;
            alures_d = mem_alures;
            ldop_d = mem_ldop;
            alo_d = mem_addr_lo;
        end
    end
    // ~alo_q equals 3-a, the LWL shift amount in bytes
    always_comb begin
        ld_byte = dbus_rdata[{alo_q, 3'b000} +: 8];
        ld_half = alo_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        ld_we = 4'hF;
        ld_data = dbus_rdata;
        case (ldop_q)
            3'd1: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd2: ld_data = {24'd0, ld_byte};
            3'd3: ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4: ld_data = {16'd0, ld_half};
            3'd6: begin
                ld_data = dbus_rdata << {~alo_q, 3'b000};
                ld_we = 4'hF << ~alo_q;
            end
            3'd7: begin
                ld_data = dbus_rdata >> {alo_q, 3'b000};
                ld_we = 4'hF >> alo_q;
            end
            default: ld_data = dbus_rdata;
        endcase
    end
    always_comb begin
        we = (state_q == WRITE) ? wreg_q :
             (state_q == WAIT && dbus_rvalid) ? (ld_we & wreg_q) : 4'b0000;
        waddr = waddr_q;
        wdata = (state_q == WAIT) ? ld_data : alures_q;
        wb_stall = state_q == WAIT && !dbus_rvalid;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            wreg_q <= '0;
            waddr_q <= '0;
            alures_q <= '0;
            ldop_q <= '0;
            alo_q <= '0;
        end else begin
            state_q <= state_d;
            wreg_q <= wreg_d;
            waddr_q <= waddr_d;
            alures_q <= alures_d;
            ldop_q <= ldop_d;
            alo_q <= alo_d;
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage
module tb_wb_stage;
    logic        clk = 0;
    logic        rst;
    logic        mem_valid;
    logic [3:0]  mem_wreg;
    logic [4:0]  mem_wraddr;
    logic [31:0] mem_alures;
    logic [2:0]  mem_ldop;
    logic [1:0]  mem_addr_lo;
    logic        stall;
    logic        flush;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wb_stall;
    int total = 0;
    int bad = 0;
    wb_stage dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wreg(mem_wreg),
        .mem_wraddr(mem_wraddr), .mem_alures(mem_alures), .mem_ldop(mem_ldop),
        .mem_addr_lo(mem_addr_lo), .stall(stall), .flush(flush),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .we(we),
        .waddr(waddr), .wdata(wdata), .wb_stall(wb_stall)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [3:0] wr, input logic [4:0] ra, input logic [31:0] res,
                         input logic [2:0] op, input logic [1:0] lo);
        mem_valid = 1; mem_wreg = wr; mem_wraddr = ra; mem_alures = res;
        mem_ldop = op; mem_addr_lo = lo;
    endtask
    task automatic idle;
        mem_valid = 0; mem_wreg = 0; mem_ldop = 0; mem_addr_lo = 0;
    endtask
    task automatic load(input string tag, input logic [2:0] op, input logic [1:0] lo,
                        input logic [3:0] wr, input logic [31:0] rd,
                        input logic [3:0] exp_we, input logic [31:0] exp_d);
        issue(wr, 5'd12, 32'h0, op, lo);
        tick;
        idle;
        dbus_rvalid = 1; dbus_rdata = rd;
        #1;
        chk({tag, "_we"}, 32'(we), 32'(exp_we));
        chk({tag, "_wdata"}, wdata, exp_d);
        tick;
        dbus_rvalid = 0;
        #1;
        chk({tag, "_after"}, 32'(we), 32'h0);
    endtask
    initial begin
        rst = 1; stall = 0; flush = 0; dbus_rvalid = 0; dbus_rdata = 0;
        mem_wraddr = 0; mem_alures = 0;
        idle;
        #3;
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_waddr", 32'(waddr), 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_stall", 32'(wb_stall), 32'h0);
        tick;
        rst = 0;
        // plain ALU write, one cycle after capture
        issue(4'hF, 5'd5, 32'h12345678, 3'd0, 2'd0);
        tick;
        idle;
        #1;
        chk("alu_we", 32'(we), 32'hF);
        chk("alu_waddr", 32'(waddr), 32'd5);
        chk("alu_wdata", wdata, 32'h12345678);
        chk("alu_stall", 32'(wb_stall), 32'h0);
        tick;
        chk("alu_once", 32'(we), 32'h0);
        // LB with a three-cycle response delay
        issue(4'hF, 5'd7, 32'hDEADBEEF, 3'd1, 2'd2);
        tick;
        idle;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("lb_wait_stall", 32'(wb_stall), 32'h1);
            chk("lb_wait_we", 32'(we), 32'h0);
            if (i < 2) tick;
        end
        tick;
        dbus_rvalid = 1; dbus_rdata = 32'h00801234;
        #1;
        chk("lb_we", 32'(we), 32'hF);
        chk("lb_wdata", wdata, 32'hFFFFFF80);
        chk("lb_waddr", 32'(waddr), 32'd7);
        chk("lb_stall", 32'(wb_stall), 32'h0);
        tick;
        dbus_rvalid = 0;
        #1;
        chk("lb_once", 32'(we), 32'h0);
        chk("lb_done_stall", 32'(wb_stall), 32'h0);
        // load formatting table
        load("lwl1", 3'd6, 2'd1, 4'hF, 32'hAABBCCDD, 4'b1100, 32'hCCDD0000);
        load("lwr1", 3'd7, 2'd1, 4'hF, 32'hAABBCCDD, 4'b0111, 32'h00AABBCC);
        load("lhu2", 3'd4, 2'd2, 4'hF, 32'hAABBCCDD, 4'hF, 32'h0000AABB);
        load("lh2", 3'd3, 2'd2, 4'hF, 32'hAABBCCDD, 4'hF, 32'hFFFFAABB);
        load("lh0", 3'd3, 2'd1, 4'hF, 32'hAABB7CDD, 4'hF, 32'h00007CDD);
        load("lwl0", 3'd6, 2'd0, 4'hF, 32'hAABBCCDD, 4'b1000, 32'hDD000000);
        load("lwl3", 3'd6, 2'd3, 4'hF, 32'hAABBCCDD, 4'hF, 32'hAABBCCDD);
        load("lwr0", 3'd7, 2'd0, 4'hF, 32'hAABBCCDD, 4'hF, 32'hAABBCCDD);
        load("lwr3", 3'd7, 2'd3, 4'hF, 32'hAABBCCDD, 4'b0001, 32'h000000AA);
        load("lb0m", 3'd1, 2'd0, 4'b0011, 32'hAABBCCDD, 4'b0011, 32'hFFFFFFDD);
        load("lbu3", 3'd2, 2'd3, 4'hF, 32'hAABBCCDD, 4'hF, 32'h000000AA);
        load("lb1", 3'd1, 2'd1, 4'hF, 32'hAABB4CDD, 4'hF, 32'h0000004C);
        load("lw", 3'd5, 2'd0, 4'hF, 32'h13579BDF, 4'hF, 32'h13579BDF);
        // back-to-back captures write every cycle
        issue(4'hF, 5'd10, 32'hA0A0A0A0, 3'd0, 2'd0);
        tick;
        issue(4'b0110, 5'd11, 32'hB1B1B1B1, 3'd0, 2'd0);
        #1;
        chk("b2b_a_addr", 32'(waddr), 32'd10);
        chk("b2b_a_we", 32'(we), 32'hF);
        tick;
        idle;
        #1;
        chk("b2b_b_addr", 32'(waddr), 32'd11);
        chk("b2b_b_we", 32'(we), 32'h6);
        chk("b2b_b_data", wdata, 32'hB1B1B1B1);
        tick;
        chk("b2b_end", 32'(we), 32'h0);
        // held instruction writes only once
        issue(4'hF, 5'd9, 32'hCAFEF00D, 3'd0, 2'd0);
        tick;
        stall = 1;
        #1;
        chk("hold_first", 32'(we), 32'hF);
        chk("hold_data", wdata, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("hold_rest", 32'(we), 32'h0);
        end
        stall = 0;
        idle;
        tick;
        chk("hold_released", 32'(we), 32'h0);
        // flushed capture becomes a bubble
        issue(4'hF, 5'd8, 32'h55555555, 3'd0, 2'd0);
        flush = 1;
        tick;
        flush = 0;
        idle;
        #1;
        chk("flush_we", 32'(we), 32'h0);
        tick;
        chk("flush_we2", 32'(we), 32'h0);
        // flush cannot cancel a load already waiting
        issue(4'hF, 5'd3, 32'h0, 3'd5, 2'd0);
        tick;
        issue(4'hF, 5'd4, 32'h11111111, 3'd0, 2'd0);
        flush = 1;
        #1;
        chk("fw_stall0", 32'(wb_stall), 32'h1);
        chk("fw_we0", 32'(we), 32'h0);
        tick;
        chk("fw_stall1", 32'(wb_stall), 32'h1);
        tick;
        chk("fw_stall2", 32'(wb_stall), 32'h1);
        dbus_rvalid = 1; dbus_rdata = 32'h13572468;
        #1;
        chk("fw_we", 32'(we), 32'hF);
        chk("fw_waddr", 32'(waddr), 32'd3);
        chk("fw_wdata", wdata, 32'h13572468);
        tick;
        dbus_rvalid = 0; flush = 0;
        idle;
        #1;
        chk("fw_flushed_we", 32'(we), 32'h0);
        tick;
        chk("fw_flushed_we2", 32'(we), 32'h0);
        // reset while waiting discards the load
        issue(4'hF, 5'd6, 32'h0, 3'd5, 2'd0);
        tick;
        idle;
        #1;
        chk("rw_stall", 32'(wb_stall), 32'h1);
        rst = 1;
        #1;
        chk("rw_rst_stall", 32'(wb_stall), 32'h0);
        chk("rw_rst_waddr", 32'(waddr), 32'h0);
        dbus_rvalid = 1; dbus_rdata = 32'hFFFFFFFF;
        #1;
        chk("rw_rst_we", 32'(we), 32'h0);
        tick;
        rst = 0;
        #1;
        chk("rw_post_we", 32'(we), 32'h0);
        chk("rw_post_stall", 32'(wb_stall), 32'h0);
        tick;
        dbus_rvalid = 0;
        #1;
        chk("rw_end_we", 32'(we), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
